// File: rtl/reg_dump.sv
// Debug register-file reader: walks FIRST_ADDR..LAST_ADDR and streams each entry
// as a 5-byte frame (address, then data MSB first) over a valid/ready byte port.
module reg_dump #(
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST = 5'(FIRST_ADDR);
  localparam logic [4:0] LAST  = 5'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_q, cur_d;
  logic [31:0] shadow_q, shadow_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        fire;
  logic        kill;

  assign fire = (state_q == SEND) && tx_ready;
  assign kill = abort && (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_q      <= FIRST;
      shadow_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Abort wins over both the start request and the frame-advance logic.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   state_d = SEND;
        SEND:    if (fire && byte_idx_q == 3'd4) state_d = (cur_q == LAST) ? DONE : FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_d      = cur_q;
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    if (!kill) begin
      case (state_q)
        IDLE: if (start) cur_d = FIRST;
        FETCH: begin
          shadow_d   = rf_data;
          byte_idx_d = '0;
        end
        SEND: begin
          if (fire) begin
            if (byte_idx_q != 3'd4) byte_idx_d = byte_idx_q + 3'd1;
            else if (cur_q != LAST) cur_d = cur_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte mux reads only registered state, so it holds steady across a stall.
  always_comb begin
    rf_addr  = cur_q;
    tx_valid = (state_q == SEND);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    tx_data  = '0;
    if (state_q == SEND) begin
      case (byte_idx_q)
        3'd0:    tx_data = {3'b000, cur_q};
        3'd1:    tx_data = shadow_q[31:24];
        3'd2:    tx_data = shadow_q[23:16];
        3'd3:    tx_data = shadow_q[15:8];
        3'd4:    tx_data = shadow_q[7:0];
        default: tx_data = '0;
      endcase
    end
  end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Synthesizable debug reader for the CPU register file.
- On a start pulse, walks register addresses FIRST_ADDR..LAST_ADDR through a spare combinational register-file read port.
- Streams each register out as a 5-byte frame over a valid/ready byte interface: address byte, then the 4 data bytes MSB first. The byte stream typically feeds the UART transmitter.
- Hardware counterpart of the simulation-only register trace: it is the path that reads register state back out of the chip.

Parameters:
- FIRST_ADDR, 0, first register address dumped (0..31).
- LAST_ADDR, 31, last register address dumped (FIRST_ADDR..31).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE at the next edge.
- rf_addr  output  5  register-file read address.
- rf_data  input  32  register-file read data, combinational from rf_addr.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  consumer accepts the byte on this edge when tx_valid=1.
- busy  output  1  a dump is in progress (state is not IDLE).
- done  output  1  one-cycle pulse after the last byte of the last frame is accepted.

Behaviour:
- Internal registers:
  - state: IDLE, FETCH, SEND, DONE.
  - cur: 5-bit current address.
  - shadow: 32-bit captured data.
  - byte_idx: 3 bits, 0..4.
- Reset (reset=0, asynchronous): state=IDLE, cur=FIRST_ADDR, shadow=0, byte_idx=0. Outputs: tx_valid=0, tx_data=0, busy=0, done=0, rf_addr=FIRST_ADDR.
- rf_addr = cur at all times.
- IDLE:
  - tx_valid=0, busy=0.
  - start=1 -> cur<=FIRST_ADDR, state<=FETCH.
  - start is ignored in every other state; there is no queuing.
- FETCH (exactly 1 cycle):
  - rf_addr settles to cur.
  - At the edge: shadow<=rf_data, byte_idx<=0, state<=SEND.
- SEND:
  - tx_valid=1.
  - tx_data: byte_idx 0 -> {3'b000,cur}; 1 -> shadow[31:24]; 2 -> shadow[23:16]; 3 -> shadow[15:8]; 4 -> shadow[7:0].
  - tx_data is driven from registered state, so it is stable while tx_valid=1 and tx_ready=0.
  - On tx_valid & tx_ready:
    - byte_idx<4 -> byte_idx++.
    - byte_idx==4 and cur!=LAST_ADDR -> cur++, state<=FETCH.
    - byte_idx==4 and cur==LAST_ADDR -> state<=DONE.
  - tx_ready=0 stalls indefinitely with no timeout.
- DONE:
  - done=1 for exactly one cycle, busy=1, tx_valid=0.
  - Then state<=IDLE.
  - A start present during DONE is ignored.
- Snapshot semantics: each register's value is the one read in its own FETCH cycle, not a global snapshot. Writes to the register file during a dump show up in registers not yet fetched.
- abort=1 in any non-IDLE state -> state<=IDLE at the next edge.
  - tx_valid drops even if a frame is partially sent; no done pulse.
  - A byte already handshaken on that same edge counts as sent.
  - abort has priority over the start/advance logic.
- Reset mid-dump: immediate return to reset values, no done pulse.
- Latency with tx_ready held at 1:
  - start edge -> first tx_valid after 2 cycles.
  - 6 cycles per register (1 FETCH + 5 SEND).
  - done asserted in cycle (LAST_ADDR-FIRST_ADDR+1)*6+1 after the start edge; 193 for the defaults.
- FIRST_ADDR==LAST_ADDR: a single 5-byte frame.
- cur never wraps past 31, because LAST_ADDR≤31.

Test Plan:
- Defaults, register file preloaded with reg[i]=0x01010101*i, tx_ready=1, pulse start -> 160 bytes. Frame i is {i, i, i, i, i} (e.g. reg 5: 05 05 05 05 05). done pulses once at cycle 193. busy=1 from cycle 1 through 193.
- Backpressure: reg[3]=0xDEADBEEF, tx_ready low 7 cycles then high, alternately -> frame for reg 3 is 03 DE AD BE EF. tx_data is unchanged throughout every stall. No byte is duplicated or skipped.
- Parameters FIRST_ADDR=29, LAST_ADDR=31 -> exactly 15 bytes starting 1D, 1E, 1F in the address positions. done is asserted at cycle 19.
- abort asserted while sending byte_idx=2 of reg 10 -> tx_valid=0 at the next cycle, state IDLE, no done. A new start then restarts from FIRST_ADDR with byte 00.
- reset driven low mid-SEND, asynchronously between edges -> tx_valid, busy, done go 0 immediately and rf_addr=FIRST_ADDR. start pulses during busy/DONE are ignored (single dump only).
